// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 10-bit CPU. Sequences instructions through
// fetch, decode, execute and memory phases, and drives the datapath strobes.
// Memory accesses wait on mem_ready. A bounded wait counter turns a stuck
// bus into a sticky FAULT.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       z_ff,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mem_re,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic [2:0] alu_op,
    output logic       ze,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int CW = $clog2(MEM_TIMEOUT);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_JZ  = 4'hB;
    localparam logic [3:0] OP_JNZ = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [3:0] OP_MOV = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_PASS = 3'd6;

    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;

    assign timeout = (cnt_q == CW'(MEM_TIMEOUT - 1));

    // State and wait-counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; reset forces every output low at once
    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 2'd0;
        alu_op   = 3'd0;
        ze       = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        state_o  = state_q;

        unique case (state_q)
            FETCH: begin
                mem_re = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECODE: begin
                state_d = (opcode == OP_HLT) ? HALT : EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                if (opcode >= OP_ADD && opcode <= OP_NOT) begin
                    alu_op = opcode[2:0] - 3'd1;
                    reg_we = 1'b1;
                    ze     = 1'b1;
                end else begin
                    case (opcode)
                        OP_CMP: begin
                            alu_op = ALU_SUB;
                            ze     = 1'b1;
                        end
                        OP_MOV: begin
                            alu_op = ALU_PASS;
                            reg_we = 1'b1;
                        end
                        OP_LDI: begin
                            reg_we = 1'b1;
                            wb_sel = WB_IMM;
                        end
                        OP_JMP: pc_load = 1'b1;
                        OP_JZ:  pc_load = z_ff;
                        OP_JNZ: pc_load = ~z_ff;
                        OP_LD, OP_ST: state_d = MEM;
                        OP_NOP: state_d = FETCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            MEM: begin
                addr_sel = 1'b1;
                if (opcode == OP_ST) begin
                    mem_we = 1'b1;
                end else begin
                    mem_re = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode == OP_LD) begin
                        reg_we = 1'b1;
                        wb_sel = WB_MEM;
                    end
                    state_d = FETCH;
                end else if (timeout) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase

        if (rst) begin
            state_d  = FETCH;
            cnt_d    = '0;
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            mem_re   = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            reg_we   = 1'b0;
            wb_sel   = 2'd0;
            alu_op   = 3'd0;
            ze       = 1'b0;
            halted   = 1'b0;
            fault    = 1'b0;
            state_o  = 3'd0;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Testbench for cpu_control_fsm. Every instruction is expanded into a queue
// of per-cycle expected output vectors, built from the instruction-level
// timing rules. Each cycle is then checked against the DUT.
module tb_cpu_control_fsm;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       z_ff = 1'b0;
    logic       mem_ready = 1'b0;
    logic       ir_load, pc_inc, pc_load, mem_re, mem_we, addr_sel, reg_we;
    logic [1:0] wb_sel;
    logic [2:0] alu_op;
    logic       ze, halted, fault;
    logic [2:0] state_o;
    logic [17:0] dutVec;

    int nVec = 0;
    int nMis = 0;

    typedef struct {
        logic        rdy;
        logic [3:0]  op;
        logic        z;
        logic [17:0] exp;
        string       tag;
    } cyc_t;

    cyc_t cycQ[$];
    cyc_t c;

    // 100 MHz style free-running clock
    always #5 clk = ~clk;

    cpu_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .z_ff(z_ff), .mem_ready(mem_ready),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .mem_re(mem_re),
        .mem_we(mem_we), .addr_sel(addr_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .ze(ze), .halted(halted), .fault(fault), .state_o(state_o)
    );

    assign dutVec = {state_o, ir_load, pc_inc, pc_load, mem_re, mem_we, addr_sel,
                     reg_we, wb_sel, alu_op, ze, halted, fault};

    function automatic logic [17:0] mk(int st, bit irl, bit pci, bit pcl, bit re, bit we,
                                       bit as, bit rwe, int wb, int alu, bit zeB,
                                       bit hl, bit fl);
        return {3'(st), irl, pci, pcl, re, we, as, rwe, 2'(wb), 3'(alu), zeB, hl, fl};
    endfunction

    // Execute-phase outputs as listed in the instruction table
    function automatic logic [17:0] execExp(logic [3:0] op, logic z);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6:
                   return mk(2, 0, 0, 0, 0, 0, 0, 1, 0, int'(op) - 1, 1, 0, 0);
            4'hD:  return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            4'hE:  return mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 6, 0, 0, 0);
            4'h7:  return mk(2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
            4'hA:  return mk(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            4'hB:  return mk(2, 0, 0, z, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            4'hC:  return mk(2, 0, 0, !z, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            default: return mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic [17:0] memExp(logic [3:0] op, bit done);
        if (op == 4'h9) return mk(3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        if (done)       return mk(3, 0, 0, 0, 1, 0, 1, 1, 2, 0, 0, 0, 0);
        return mk(3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic cyc_t mkCyc(logic rdy, logic [3:0] op, logic z, logic [17:0] e, string t);
        cyc_t r;
        r.rdy = rdy; r.op = op; r.z = z; r.exp = e; r.tag = t;
        return r;
    endfunction

    // Expand one instruction into cycles: fw fetch waits, mw memory waits.
    // A wait count of TO or more runs into the timeout and ends in FAULT.
    task automatic build_instr(input logic [3:0] op, input int fw, input int mw, input logic zEx);
        for (int i = 0; i < fw && i < TO; i++)
            cycQ.push_back(mkCyc(1'b0, 4'($urandom), 1'($urandom),
                                 mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_wait"));
        if (fw >= TO) begin
            for (int i = 0; i < 4; i++)
                cycQ.push_back(mkCyc(1'($urandom), op, 1'($urandom),
                                     mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "fault"));
            return;
        end
        cycQ.push_back(mkCyc(1'b1, 4'($urandom), 1'($urandom),
                             mk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "fetch_done"));
        cycQ.push_back(mkCyc(1'($urandom), op, 1'($urandom),
                             mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode"));
        if (op == 4'hF) begin
            for (int i = 0; i < 4; i++)
                cycQ.push_back(mkCyc(1'(i), op, 1'($urandom),
                                     mk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "halt"));
            return;
        end
        cycQ.push_back(mkCyc(1'($urandom), op, zEx, execExp(op, zEx), "exec"));
        if (op == 4'h8 || op == 4'h9) begin
            for (int i = 0; i < mw && i < TO; i++)
                cycQ.push_back(mkCyc(1'b0, op, 1'($urandom), memExp(op, 0), "mem_wait"));
            if (mw >= TO) begin
                for (int i = 0; i < 4; i++)
                    cycQ.push_back(mkCyc(1'($urandom), op, 1'($urandom),
                                         mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "fault"));
                return;
            end
            cycQ.push_back(mkCyc(1'b1, op, 1'($urandom), memExp(op, 1), "mem_done"));
        end
    endtask

    // Apply one cycle of inputs after the falling edge and let outputs settle
    task automatic drive_cycle(input logic r, input logic rdy, input logic [3:0] op, input logic z);
        @(negedge clk);
        rst = r; mem_ready = rdy; opcode = op; z_ff = z;
        #1;
    endtask

    task automatic hold_reset();
        drive_cycle(1'b1, 1'b0, 4'h0, 1'b0);
        drive_cycle(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_cycle(1'b1, 1'($urandom), 4'($urandom), 1'($urandom));
            nVec++;
            if (dutVec !== 18'h0) begin
                nMis++;
                $display("[TB] FAIL reset_outputs: got %05h expected %05h", dutVec, 18'h0);
            end
        end
        drive_cycle(1'b0, 1'b0, 4'h3, 1'b0);
        nVec++;
        if (dutVec !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            nMis++;
            $display("[TB] FAIL reset_exit_fetch: got %05h expected %05h",
                     dutVec, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_alu();
        hold_reset();
        for (int op = 1; op <= 14; op++)
            if (op != 8 && op != 9) build_instr(4'(op), 0, 0, 1'($urandom));
        build_instr(4'h0, 0, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL alu_%s op=%h: got %05h expected %05h", c.tag, c.op, dutVec, c.exp);
            end
        end
    endtask

    task automatic test_branch();
        hold_reset();
        build_instr(4'hB, 0, 0, 1'b1);
        build_instr(4'hB, 0, 0, 1'b0);
        build_instr(4'hC, 0, 0, 1'b1);
        build_instr(4'hC, 0, 0, 1'b0);
        build_instr(4'hA, 1, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL branch_%s op=%h z=%b: got %05h expected %05h",
                         c.tag, c.op, c.z, dutVec, c.exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        hold_reset();
        build_instr(4'h8, 0, 3, 1'b0);
        build_instr(4'h9, 2, 2, 1'b0);
        build_instr(4'h8, TO - 1, TO - 1, 1'b0);
        build_instr(4'h9, 0, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL mem_%s op=%h: got %05h expected %05h", c.tag, c.op, dutVec, c.exp);
            end
        end
    endtask

    task automatic test_timeout();
        hold_reset();
        build_instr(4'h1, TO, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL fetch_timeout_%s: got %05h expected %05h", c.tag, dutVec, c.exp);
            end
        end
        drive_cycle(1'b1, 1'b1, 4'h0, 1'b0);
        drive_cycle(1'b0, 1'b0, 4'h0, 1'b0);
        nVec++;
        if (dutVec !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            nMis++;
            $display("[TB] FAIL fault_reset_exit: got %05h expected %05h",
                     dutVec, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        hold_reset();
        build_instr(4'h8, 0, TO, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL mem_timeout_%s: got %05h expected %05h", c.tag, dutVec, c.exp);
            end
        end
    endtask

    task automatic test_halt();
        hold_reset();
        build_instr(4'h2, 0, 0, 1'b0);
        build_instr(4'hF, 1, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL halt_%s: got %05h expected %05h", c.tag, dutVec, c.exp);
            end
        end
    endtask

    task automatic test_rst_mid_st();
        hold_reset();
        build_instr(4'h9, 0, TO - 1, 1'b0);
        for (int i = 0; i < 4 + 3; i++) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL st_abort_%s: got %05h expected %05h", c.tag, dutVec, c.exp);
            end
        end
        cycQ.delete();
        drive_cycle(1'b1, 1'b0, 4'h9, 1'b0);
        nVec++;
        if (dutVec !== 18'h0) begin
            nMis++;
            $display("[TB] FAIL st_abort_rst_cycle: got %05h expected %05h", dutVec, 18'h0);
        end
        drive_cycle(1'b0, 1'b0, 4'h9, 1'b0);
        nVec++;
        if (dutVec !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            nMis++;
            $display("[TB] FAIL st_abort_next_fetch: got %05h expected %05h",
                     dutVec, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        hold_reset();
        for (int n = 0; n < 60; n++)
            build_instr(4'($urandom_range(14)), int'($urandom_range(4)),
                        int'($urandom_range(4)), 1'($urandom));
        build_instr(4'hF, 0, 0, 1'b0);
        while (cycQ.size() > 0) begin
            c = cycQ.pop_front();
            drive_cycle(1'b0, c.rdy, c.op, c.z);
            nVec++;
            if (dutVec !== c.exp) begin
                nMis++;
                $display("[TB] FAIL random_%s op=%h: got %05h expected %05h", c.tag, c.op, dutVec, c.exp);
            end
        end
    endtask

    // Scenario sequence followed by the summary line
    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_halt();
        test_rst_mid_st();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
